// File: rtl/fifo_bram_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port BRAM
// with a registered port-B read, a two-entry output stage (head + skid) and one fetch in flight.
module fifo_bram_ctrl #(
  parameter int unsigned addr_width = 10,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [data_width-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [addr_width:0]   count,
  output logic                  mem_we_a,
  output logic [addr_width-1:0] mem_addr_a,
  output logic [data_width-1:0] mem_din_a,
  output logic                  mem_we_b,
  output logic [addr_width-1:0] mem_addr_b,
  output logic [data_width-1:0] mem_din_b,
  input  logic [data_width-1:0] mem_dout_b
);

  localparam int unsigned depth = 1 << addr_width;
  localparam int unsigned cnt_w = addr_width + 1;

  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [cnt_w-1:0]      mem_cnt;
  logic                  pend;
  logic                  head_v;
  logic                  skid_v;
  logic [data_width-1:0] head;
  logic [data_width-1:0] skid;
  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic [1:0]            in_flight;

  // Fetch only while the output stage can absorb the returning word.
  always_comb begin
    push      = wr_valid && wr_ready;
    pop       = head_v && rd_ready;
    in_flight = 2'(head_v) + 2'(skid_v) + 2'(pend);
    fetch     = (mem_cnt != '0) && (in_flight < (2'd2 + 2'(pop)));
  end

  assign wr_ready   = count < cnt_w'(depth);
  assign rd_valid   = head_v;
  assign rd_data    = head;
  assign mem_we_a   = push && !rst;
  assign mem_addr_a = wr_ptr;
  assign mem_din_a  = wr_data;
  assign mem_we_b   = 1'b0;
  assign mem_addr_b = rd_ptr;
  assign mem_din_b  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      count   <= '0;
      pend    <= 1'b0;
      head_v  <= 1'b0;
      skid_v  <= 1'b0;
      head    <= '0;
      skid    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + addr_width'(1);
      if (fetch) rd_ptr <= rd_ptr + addr_width'(1);
      mem_cnt <= mem_cnt + cnt_w'(push) - cnt_w'(fetch);
      count   <= count + cnt_w'(push) - cnt_w'(pop);
      pend    <= fetch;
      // Returning BRAM word lands in head when head frees up, otherwise in skid.
      if (pop && skid_v) begin
        head   <= skid;
        head_v <= 1'b1;
        skid_v <= pend;
        if (pend) skid <= mem_dout_b;
      end else if (pop) begin
        head_v <= pend;
        if (pend) head <= mem_dout_b;
      end else if (pend) begin
        if (!head_v) begin
          head   <= mem_dout_b;
          head_v <= 1'b1;
        end else begin
          skid   <= mem_dout_b;
          skid_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_bram_ctrl.sv
// Directed scoreboard bench for fifo_bram_ctrl: a 16-deep instance for the main scenarios
// and a 4-deep instance for pointer wrap-around.
module tb_fifo_bram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16-deep instance
  logic       a_wv, a_wr, a_rv, a_rr, a_we_a, a_we_b;
  logic [7:0] a_wd, a_rd, a_din_a, a_din_b, a_dout_b;
  logic [4:0] a_cnt;
  logic [3:0] a_addr_a, a_addr_b;
  logic [7:0] a_mem [16];

  // 4-deep instance
  logic       b_wv, b_wr, b_rv, b_rr, b_we_a, b_we_b;
  logic [7:0] b_wd, b_rd, b_din_a, b_din_b, b_dout_b;
  logic [2:0] b_cnt;
  logic [1:0] b_addr_a, b_addr_b;
  logic [7:0] b_mem [4];

  fifo_bram_ctrl #(.addr_width(4), .data_width(8)) u_dut_a (
    .clk(clk), .rst(rst), .wr_valid(a_wv), .wr_data(a_wd), .wr_ready(a_wr),
    .rd_valid(a_rv), .rd_data(a_rd), .rd_ready(a_rr), .count(a_cnt),
    .mem_we_a(a_we_a), .mem_addr_a(a_addr_a), .mem_din_a(a_din_a),
    .mem_we_b(a_we_b), .mem_addr_b(a_addr_b), .mem_din_b(a_din_b), .mem_dout_b(a_dout_b)
  );

  fifo_bram_ctrl #(.addr_width(2), .data_width(8)) u_dut_b (
    .clk(clk), .rst(rst), .wr_valid(b_wv), .wr_data(b_wd), .wr_ready(b_wr),
    .rd_valid(b_rv), .rd_data(b_rd), .rd_ready(b_rr), .count(b_cnt),
    .mem_we_a(b_we_a), .mem_addr_a(b_addr_a), .mem_din_a(b_din_a),
    .mem_we_b(b_we_b), .mem_addr_b(b_addr_b), .mem_din_b(b_din_b), .mem_dout_b(b_dout_b)
  );

  // BRAM models with registered port-B read
  always @(posedge clk) begin
    if (a_we_a) a_mem[a_addr_a] <= a_din_a;
    a_dout_b <= a_mem[a_addr_b];
    if (b_we_a) b_mem[b_addr_a] <= b_din_a;
    b_dout_b <= b_mem[b_addr_b];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ea_cnt, eb_cnt, a_wp, b_wp;
  logic [1:0] b_prev_addr_b, b_prev_addr_a;
  logic b_wrap_a, b_wrap_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input bit wv, input logic [7:0] wd, input bit rr);
    bit push, pop;
    a_wv = wv; a_wd = wd; a_rr = rr;
    #1;
    push = wv && (ea_cnt < 16);
    chk("a_wr_ready", 32'(a_wr), 32'(ea_cnt < 16));
    chk("a_mem_we_a", 32'(a_we_a), 32'(push));
    chk("a_mem_we_b", 32'(a_we_b), 32'(0));
    if (push) begin
      chk("a_mem_addr_a", 32'(a_addr_a), 32'(a_wp));
      chk("a_mem_din_a", 32'(a_din_a), 32'(wd));
    end
    pop = rr && (a_rv === 1'b1);
    if (pop) begin
      if (qa.size() > 0) chk("a_rd_data", 32'(a_rd), 32'(qa.pop_front()));
      else chk("a_rd_valid_spurious", 32'(a_rv), 32'(0));
    end
    if (push) begin
      qa.push_back(wd);
      a_wp = (a_wp + 1) % 16;
    end
    ea_cnt += int'(push) - int'(pop);
    @(posedge clk);
    #1;
    chk("a_count", 32'(a_cnt), 32'(ea_cnt));
  endtask

  task automatic step_b(input bit wv, input logic [7:0] wd, input bit rr);
    bit push, pop;
    b_wv = wv; b_wd = wd; b_rr = rr;
    #1;
    push = wv && (eb_cnt < 4);
    chk("b_wr_ready", 32'(b_wr), 32'(eb_cnt < 4));
    chk("b_mem_we_a", 32'(b_we_a), 32'(push));
    if (push) begin
      chk("b_mem_addr_a", 32'(b_addr_a), 32'(b_wp));
      if (b_prev_addr_a == 2'd3 && b_addr_a == 2'd0) b_wrap_a = 1'b1;
      b_prev_addr_a = b_addr_a;
    end
    pop = rr && (b_rv === 1'b1);
    if (pop) begin
      if (qb.size() > 0) chk("b_rd_data", 32'(b_rd), 32'(qb.pop_front()));
      else chk("b_rd_valid_spurious", 32'(b_rv), 32'(0));
    end
    if (push) begin
      qb.push_back(wd);
      b_wp = (b_wp + 1) % 4;
    end
    eb_cnt += int'(push) - int'(pop);
    @(posedge clk);
    #1;
    chk("b_count", 32'(b_cnt), 32'(eb_cnt));
    if (b_prev_addr_b == 2'd3 && b_addr_b == 2'd0) b_wrap_b = 1'b1;
    b_prev_addr_b = b_addr_b;
  endtask

  // Reset both instances with pushes offered, so write-enable gating is exercised
  task automatic do_reset();
    rst = 1'b1;
    a_wv = 1'b1; a_wd = 8'hEE; a_rr = 1'b0;
    b_wv = 1'b1; b_wd = 8'hDD; b_rr = 1'b0;
    #1;
    chk("a_we_a_in_rst", 32'(a_we_a), 32'(0));
    chk("b_we_a_in_rst", 32'(b_we_a), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_wv = 1'b0; b_wv = 1'b0;
    qa.delete(); qb.delete();
    ea_cnt = 0; eb_cnt = 0; a_wp = 0; b_wp = 0;
    chk("a_rst_count", 32'(a_cnt), 32'(0));
    chk("a_rst_rd_valid", 32'(a_rv), 32'(0));
    chk("a_rst_rd_data", 32'(a_rd), 32'(0));
    chk("a_rst_wr_ready", 32'(a_wr), 32'(1));
    chk("b_rst_count", 32'(b_cnt), 32'(0));
    chk("b_rst_wr_ready", 32'(b_wr), 32'(1));
  endtask

  initial begin
    int sent;
    bit seen;
    b_prev_addr_a = 2'd0; b_prev_addr_b = 2'd0;
    b_wrap_a = 1'b0; b_wrap_b = 1'b0;
    do_reset();

    // Empty push: visible two edges after the write edge
    step_a(1'b1, 8'hA5, 1'b0);
    chk("a_lat_edge_n", 32'(a_rv), 32'(0));
    step_a(1'b0, 8'h00, 1'b0);
    chk("a_lat_edge_n1", 32'(a_rv), 32'(0));
    step_a(1'b0, 8'h00, 1'b0);
    chk("a_lat_edge_n2_valid", 32'(a_rv), 32'(1));
    chk("a_lat_edge_n2_data", 32'(a_rd), 32'(8'hA5));
    step_a(1'b0, 8'h00, 1'b1);
    chk("a_lat_drained", 32'(a_rv), 32'(0));

    // Fill to full, then one refused push, then drain in order
    for (int i = 0; i < 16; i++) step_a(1'b1, 8'(i), 1'b0);
    chk("a_full_count", 32'(a_cnt), 32'(16));
    chk("a_full_wr_ready", 32'(a_wr), 32'(0));
    step_a(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 40 && qa.size() > 0; i++) step_a(1'b0, 8'h00, 1'b1);
    chk("a_fill_drain_done", 32'(qa.size()), 32'(0));
    chk("a_fill_empty_valid", 32'(a_rv), 32'(0));

    // Streaming 0..99 with rd_ready held high
    sent = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 400 && (sent < 100 || qa.size() > 0); cyc++) begin
      if (seen && qa.size() > 0) chk("a_stream_no_gap", 32'(a_rv), 32'(1));
      if (a_rv === 1'b1) seen = 1'b1;
      chk("a_stream_count_le3", 32'(a_cnt <= 5'd3), 32'(1));
      step_a(sent < 100, 8'(sent), 1'b1);
      if (sent < 100) sent++;
    end
    chk("a_stream_sent", 32'(sent), 32'(100));
    chk("a_stream_drained", 32'(qa.size()), 32'(0));

    // Backpressure: 0x11 held while 0x22 and 0x33 queue behind it
    step_a(1'b1, 8'h11, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("a_bp_valid", 32'(a_rv), 32'(1));
      chk("a_bp_hold", 32'(a_rd), 32'(8'h11));
      step_a(k < 2, (k == 0) ? 8'h22 : 8'h33, 1'b0);
    end
    chk("a_bp_hold_end", 32'(a_rd), 32'(8'h11));
    for (int i = 0; i < 20 && qa.size() > 0; i++) step_a(1'b0, 8'h00, 1'b1);
    chk("a_bp_drained", 32'(qa.size()), 32'(0));

    // Reset with count=5 and a fetch in flight
    for (int i = 0; i < 5; i++) step_a(1'b1, 8'(8'h40 + i), 1'b0);
    step_a(1'b1, 8'h45, 1'b1);
    chk("a_midrst_pre_count", 32'(a_cnt), 32'(5));
    do_reset();
    step_a(1'b1, 8'h7E, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    chk("a_midrst_first_valid", 32'(a_rv), 32'(1));
    chk("a_midrst_first_data", 32'(a_rd), 32'(8'h7E));
    step_a(1'b0, 8'h00, 1'b1);
    step_a(1'b0, 8'h00, 1'b0);
    step_a(1'b0, 8'h00, 1'b0);
    chk("a_midrst_no_stale", 32'(a_rv), 32'(0));

    // Wrap-around on the 4-deep instance
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 3; k++) step_b(1'b1, 8'(it * 3 + k + 1), 1'b0);
      for (int k = 0; k < 10 && qb.size() > 0; k++) step_b(1'b0, 8'h00, 1'b1);
      chk("b_wrap_drained", 32'(qb.size()), 32'(0));
    end
    chk("b_addr_a_wrapped", 32'(b_wrap_a), 32'(1));
    chk("b_addr_b_wrapped", 32'(b_wrap_b), 32'(1));
    chk("b_mem_we_b_tied", 32'(b_we_b), 32'(0));
    chk("b_mem_din_b_tied", 32'(b_din_b), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
